// File: rtl/alu_result_select.sv
// Result-select stage: ORs enabled ALU unit lanes, flags non-one-hot selects, and presents the
// record through a registered valid/ready output with a 2-entry skid. Optional perf counters
// are enabled by defining ALU_RESULT_SELECT_PERF_EN.
module alu_result_select #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_UNITS = 3,
    parameter int unsigned SEL_W     = $clog2(NUM_UNITS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_UNITS*WIDTH-1:0] in_data,
    input  logic [NUM_UNITS-1:0]       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [SEL_W-1:0]           out_sel,
    output logic                       out_err,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef ALU_RESULT_SELECT_PERF_EN
    ,
    output logic [15:0]                perf_xfer_cnt,
    output logic [15:0]                perf_err_cnt
`endif
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] rec_data;
    logic [SEL_W-1:0] rec_sel;
    logic             rec_err;
    int unsigned      rec_ones;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             skid_err_q, skid_err_d;

    logic accept;
    logic pop;
    logic load_out;
    logic load_skid;
    logic out_from_skid;

    // Walk lanes high to low so the last hit leaves the lowest set index in rec_sel.
    always_comb begin
        rec_data = '0;
        rec_sel  = '0;
        rec_ones = 0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (en[i]) begin
                rec_data = rec_data | in_data[i*WIDTH +: WIDTH];
                rec_sel  = SEL_W'(i);
                rec_ones = rec_ones + 1;
            end
        end
        rec_err = (rec_ones != 1);
    end

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_q && out_ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d  = StOne;
                    load_out = 1'b1;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = StTwo;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    state_d       = StOne;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_err_d   = out_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;
        if (load_out) begin
            out_data_d = rec_data;
            out_sel_d  = rec_sel;
            out_err_d  = rec_err;
        end else if (out_from_skid) begin
            out_data_d = skid_data_q;
            out_sel_d  = skid_sel_q;
            out_err_d  = skid_err_q;
        end
        if (load_skid) begin
            skid_data_d = rec_data;
            skid_sel_d  = rec_sel;
            skid_err_d  = rec_err;
        end
        // Handshake flags are registered from the next state so in_ready never sees out_ready.
        out_valid_d = (state_d != StEmpty);
        in_ready_d  = (state_d != StTwo);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

`ifdef ALU_RESULT_SELECT_PERF_EN
    logic [15:0] xfer_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (pop) begin
            if (xfer_cnt_q != 16'hFFFF) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            if (out_err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign perf_xfer_cnt = xfer_cnt_q;
    assign perf_err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_select.sv
// Self-checking bench for alu_result_select: directed steps plus a negedge scoreboard monitor
// that checks ordering, stability, in_ready and that nothing stale is ever emitted.
module tb_alu_result_select;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        err;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] in_data;
    logic [2:0]  en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
`ifdef ALU_RESULT_SELECT_PERF_EN
    logic [15:0] perf_xfer_cnt;
    logic [15:0] perf_err_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   pop_cnt  = 0;
    rec_t sb[$];

    alu_result_select #(
        .WIDTH    (32),
        .NUM_UNITS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_err  (out_err),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef ALU_RESULT_SELECT_PERF_EN
        ,
        .perf_xfer_cnt(perf_xfer_cnt),
        .perf_err_cnt (perf_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t model(input logic [95:0] d, input logic [2:0] e);
        rec_t r;
        logic found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (e[i]) begin
                r.data = r.data | d[i*32 +: 32];
                if (!found) r.sel = 2'(i);
                found = 1'b1;
            end
        end
        r.err = ($countones(e) != 1);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [2:0] e, input logic [31:0] l0,
                         input logic [31:0] l1, input logic [31:0] l2);
        in_valid = v;
        en       = e;
        in_data  = {l2, l1, l0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && out_valid; k++) step();
        check("drain_timeout", out_valid, 1'b0);
    endtask

    // Scoreboard monitor: checks before pushing this cycle's accepted record.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            check("in_ready_model", in_ready, sb.size() < 2);
            if (out_valid) begin
                check("sb_nonempty", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    check("sb_data", out_data, sb[0].data);
                    check("sb_sel", out_sel, sb[0].sel);
                    check("sb_err", out_err, sb[0].err);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        pop_cnt++;
                    end
                end
            end else begin
                check("sb_empty_when_idle", sb.size(), 0);
            end
            if (in_valid && in_ready) sb.push_back(model(in_data, en));
        end
    end

    initial begin
        int pops_before;
        logic ready_dropped;

        // 1. Reset then single transfer
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_sel", out_sel, 2'd0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        drive(1'b1, 3'b010, 32'h0, 32'hA5A5_0001, 32'h0);
        step();
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, 32'hA5A5_0001);
        check("t1_sel", out_sel, 2'd1);
        check("t1_err", out_err, 1'b0);
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        check("t1_valid_after", out_valid, 1'b0);

        // 2. Multi-hot and zero-hot selects
        drive(1'b1, 3'b101, 32'h0000_00F0, 32'hDEAD_BEEF, 32'h0F00_0000);
        step();
        check("t2_multi_data", out_data, 32'h0F00_00F0);
        check("t2_multi_sel", out_sel, 2'd0);
        check("t2_multi_err", out_err, 1'b1);
        drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        check("t2_zero_data", out_data, 32'h0);
        check("t2_zero_sel", out_sel, 2'd0);
        check("t2_zero_err", out_err, 1'b1);
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        drain();

        // 3. Back-pressure into the skid entry
        pops_before = pop_cnt;
        out_ready   = 1'b0;
        drive(1'b1, 3'b001, 32'h1111_000A, 32'h0, 32'h0);
        step();
        drive(1'b1, 3'b100, 32'h0, 32'h0, 32'hBBBB_000B);
        step();
        check("t3_data_a", out_data, 32'h1111_000A);
        check("t3_in_ready_full", in_ready, 1'b0);
        drive(1'b1, 3'b010, 32'h0, 32'hCCCC_000C, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_hold_data", out_data, 32'h1111_000A);
            check("t3_hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && !in_ready; k++) step();
        check("t3_ready_timeout", in_ready, 1'b1);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        drain();
        check("t3_pop_count", pop_cnt - pops_before, 3);

        // 4. Full throughput with random one-hot selects
        pops_before   = pop_cnt;
        ready_dropped = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!in_ready) ready_dropped = 1'b1;
            drive(1'b1, 3'b001 << $urandom_range(0, 2), $urandom, $urandom, $urandom);
            step();
        end
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        check("t4_pops_in_101", pop_cnt - pops_before, 100);
        check("t4_ready_dropped", ready_dropped, 1'b0);
        drain();

        // 5. Reset while full discards held records
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 32'h5555_0001, 32'h0, 32'h0);
        step();
        drive(1'b1, 3'b010, 32'h0, 32'h5555_0002, 32'h0);
        step();
        check("t5_full", in_ready, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_ready", in_ready, 1'b1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'b100, 32'h0, 32'h0, 32'h7777_000D);
        step();
        check("t5_first_accept_valid", out_valid, 1'b1);
        check("t5_first_accept_data", out_data, 32'h7777_000D);
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) step();
        check("t5_no_stale", out_valid, 1'b0);

`ifdef ALU_RESULT_SELECT_PERF_EN
        // 6. Counter saturation: 70000 pops, 3 flagged; counts start from the reset above
        for (int k = 0; k < 70000; k++) begin
            if (k == 10 || k == 20000 || k == 50000) begin
                drive(1'b1, 3'b000, $urandom, $urandom, $urandom);
            end else begin
                drive(1'b1, 3'b001 << $urandom_range(0, 2), $urandom, $urandom, $urandom);
            end
            step();
        end
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        drain();
        check("t6_xfer_sat", perf_xfer_cnt, 16'hFFFF);
        check("t6_err_cnt", perf_err_cnt, 16'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
